debug_scan_master: RTL

//   Bus master for the debug check bus (chk_addr -> chk_data). On a start request it

---
 rtl/debug_scan_master.sv | 118 +++++++++++
 1 files changed

// File: rtl/debug_scan_master.sv
// Debug check-bus scan master: walks a contiguous address range, waits a settle
// time at each address, then streams {addr, data} records on a valid/ready port.
module debug_scan_master #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic [31:0]      chk_addr,
    input  logic [31:0]      chk_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, SETTLE, SEND, FIN} state_t;

    localparam logic [3:0] SCNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] rem_reg;
    logic [3:0]       scnt_reg;
    logic [31:0]      chk_addr_reg;
    logic [31:0]      out_addr_reg;
    logic [31:0]      out_data_reg;
    logic             out_valid_reg;
    logic             busy_reg;
    logic             done_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            rem_reg       <= '0;
            scnt_reg      <= 4'd0;
            chk_addr_reg  <= 32'd0;
            out_addr_reg  <= 32'd0;
            out_data_reg  <= 32'd0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            // done is raised only on the transition into FIN, so it lasts one cycle
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        if (count != '0) begin
                            chk_addr_reg <= base_addr;
                            rem_reg      <= count;
                            scnt_reg     <= SCNT_INIT;
                            state_reg    <= SETTLE;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= FIN;
                        end
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (scnt_reg != 4'd0) begin
                        scnt_reg <= scnt_reg - 4'd1;
                    end else begin
                        out_addr_reg  <= chk_addr_reg;
                        out_data_reg  <= chk_data;
                        out_valid_reg <= 1'b1;
                        state_reg     <= SEND;
                    end
                end
                SEND: begin
                    // abort wins over a handshake arriving in the same cycle
                    if (abort) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (rem_reg == CNT_W'(1)) begin
                            done_reg  <= 1'b1;
                            state_reg <= FIN;
                        end else begin
                            chk_addr_reg <= chk_addr_reg + 32'd1;
                            rem_reg      <= rem_reg - CNT_W'(1);
                            scnt_reg     <= SCNT_INIT;
                            state_reg    <= SETTLE;
                        end
                    end
                end
                FIN: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    // chk_addr is never cleared after a scan so the responder output stays stable
    assign chk_addr  = chk_addr_reg;
    assign out_valid = out_valid_reg;
    assign out_addr  = out_addr_reg;
    assign out_data  = out_data_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
